// File: rtl/uart_line_pkg.sv
// Shared types for the UART line collector: FSM states, LF constant and the queued line record.
package uart_line_pkg;

    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned LEN_W      = $clog2(LINE_BYTES + 1);
    localparam logic [7:0]  ASCII_LF   = 8'h0A;

    typedef enum logic [2:0] {
        StCollect,
        StPend,
        StFlush,
        StDrain,
        StTrapped
    } uart_line_state_e;

    typedef struct packed {
        logic [8*LINE_BYTES-1:0] data;
        logic [LEN_W-1:0]        len;
        logic                    partial;
    } uart_line_t;

endpackage

// File: rtl/uart_line_if.sv
// Line output handshake: the collector is master, the printer is slave.
interface uart_line_if #(
    parameter int unsigned LINE_BYTES = uart_line_pkg::LINE_BYTES
);
    localparam int unsigned LenW = $clog2(LINE_BYTES + 1);

    logic                    line_valid;
    logic                    line_ready;
    logic [8*LINE_BYTES-1:0] line_data;
    logic [LenW-1:0]         line_len;
    logic                    line_partial;

    modport master (
        output line_valid,
        output line_data,
        output line_len,
        output line_partial,
        input  line_ready
    );

    modport slave (
        input  line_valid,
        input  line_data,
        input  line_len,
        input  line_partial,
        output line_ready
    );

endinterface

// File: rtl/uart_line_fifo.sv
// Line FIFO with a registered head entry; push while full is accepted only alongside a pop.
module uart_line_fifo
    import uart_line_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  uart_line_t push_line_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output uart_line_t head_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    uart_line_t      mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    uart_line_t      head_q, head_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = head_q;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        head_d = '0;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (do_push) wptr_d = wptr_q + PtrW'(1);
        if (do_pop)  rptr_d = rptr_q + PtrW'(1);
        // The pushed entry becomes head directly when nothing older remains.
        if (cnt_d != '0) begin
            if (do_push && ((cnt_q == '0) || (cnt_q == CntW'(1) && do_pop))) begin
                head_d = push_line_i;
            end else begin
                head_d = mem_q[rptr_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_line_i;
    end

endmodule

// File: rtl/uart_line_collector.sv
// Collects the SoC UART character stream into lines, queues them for a printer and
// raises a sticky trap flag once all text preceding the good-trap character has drained.
module uart_line_collector #(
    parameter int unsigned LINE_BYTES = uart_line_pkg::LINE_BYTES,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDLE_FLUSH = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_uart_out_valid,
    input  logic [7:0]        io_uart_out_ch,
    uart_line_if.master       line_if,
    output logic              trap_hit,
    output logic [6:0]        trap_code,
    output logic [31:0]       drop_cnt
);

    import uart_line_pkg::*;

    localparam int unsigned LenW  = $clog2(LINE_BYTES + 1);
    localparam int unsigned IdleW = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;

    uart_line_state_e        state_q, state_d;
    logic [8*LINE_BYTES-1:0] buf_q, buf_d, buf_app;
    logic [LenW-1:0]         len_q, len_d, len_inc;
    logic                    partial_q, partial_d;
    logic [IdleW-1:0]        idle_q, idle_d;
    logic [6:0]              trap_code_q, trap_code_d;
    logic [31:0]             drop_q, drop_d;

    logic       is_trap, is_char, is_lf, line_done;
    logic       push, pop, can_push, fifo_full, fifo_empty;
    uart_line_t push_line, head;

    assign is_trap = io_uart_out_valid & io_uart_out_ch[7];
    assign is_char = io_uart_out_valid & ~io_uart_out_ch[7];
    assign is_lf   = (io_uart_out_ch == ASCII_LF);

    assign pop      = line_if.line_valid & line_if.line_ready;
    assign can_push = ~fifo_full | pop;

    assign len_inc   = len_q + LenW'(1);
    assign line_done = is_lf || (len_inc == LenW'(LINE_BYTES));

    always_comb begin
        buf_app = buf_q;
        for (int unsigned i = 0; i < LINE_BYTES; i++) begin
            if (len_q == LenW'(i)) buf_app[8*i +: 8] = io_uart_out_ch;
        end
    end

    always_comb begin
        state_d           = state_q;
        buf_d             = buf_q;
        len_d             = len_q;
        partial_d         = partial_q;
        idle_d            = idle_q;
        trap_code_d       = trap_code_q;
        drop_d            = drop_q;
        push              = 1'b0;
        push_line.data    = buf_q;
        push_line.len     = len_q;
        push_line.partial = partial_q;

        unique case (state_q)
            StCollect: begin
                if (is_trap) begin
                    trap_code_d = io_uart_out_ch[6:0];
                    idle_d      = '0;
                    if (len_q != '0) begin
                        partial_d = 1'b1;
                        state_d   = StFlush;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (is_char) begin
                    idle_d = '0;
                    if (line_done) begin
                        push_line.data    = buf_app;
                        push_line.len     = len_inc;
                        push_line.partial = ~is_lf;
                        if (can_push) begin
                            push      = 1'b1;
                            buf_d     = '0;
                            len_d     = '0;
                            partial_d = 1'b0;
                        end else begin
                            buf_d     = buf_app;
                            len_d     = len_inc;
                            partial_d = ~is_lf;
                            state_d   = StPend;
                        end
                    end else begin
                        buf_d = buf_app;
                        len_d = len_inc;
                    end
                end else if (IDLE_FLUSH != 0 && len_q != '0) begin
                    if (idle_q == IdleW'(IDLE_FLUSH - 1)) begin
                        idle_d            = '0;
                        push_line.partial = 1'b1;
                        if (can_push) begin
                            push      = 1'b1;
                            buf_d     = '0;
                            len_d     = '0;
                            partial_d = 1'b0;
                        end else begin
                            partial_d = 1'b1;
                            state_d   = StPend;
                        end
                    end else begin
                        idle_d = idle_q + IdleW'(1);
                    end
                end
            end
            StPend: begin
                if (is_trap) begin
                    trap_code_d = io_uart_out_ch[6:0];
                    state_d     = StFlush;
                end else begin
                    if (is_char && drop_q != '1) drop_d = drop_q + 32'd1;
                    if (can_push) begin
                        push      = 1'b1;
                        buf_d     = '0;
                        len_d     = '0;
                        partial_d = 1'b0;
                        state_d   = StCollect;
                    end
                end
            end
            StFlush: begin
                if (can_push) begin
                    push      = 1'b1;
                    buf_d     = '0;
                    len_d     = '0;
                    partial_d = 1'b0;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty) state_d = StTrapped;
            end
            StTrapped: begin
                state_d = StTrapped;
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StCollect;
            buf_q       <= '0;
            len_q       <= '0;
            partial_q   <= 1'b0;
            idle_q      <= '0;
            trap_code_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            len_q       <= len_d;
            partial_q   <= partial_d;
            idle_q      <= idle_d;
            trap_code_q <= trap_code_d;
            drop_q      <= drop_d;
        end
    end

    uart_line_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (push),
        .push_line_i (push_line),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign line_if.line_valid   = ~fifo_empty;
    assign line_if.line_data    = head.data;
    assign line_if.line_len     = head.len;
    assign line_if.line_partial = head.partial;

    assign trap_hit  = (state_q == StTrapped);
    assign trap_code = trap_code_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_uart_line_collector.sv
// Directed bench for uart_line_collector: expected lines are queued as characters are
// driven and compared when the printer side accepts them.
module tb_uart_line_collector;

    localparam int unsigned LB = 64;

    typedef struct {
        logic [8*LB-1:0] data;
        int              len;
        bit              partial;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        io_uart_out_valid;
    logic [7:0]  io_uart_out_ch;
    logic        trap_hit;
    logic [6:0]  trap_code;
    logic [31:0] drop_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    uart_line_if #(.LINE_BYTES(LB)) lif ();

    uart_line_collector #(
        .LINE_BYTES (LB),
        .FIFO_DEPTH (4),
        .IDLE_FLUSH (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_uart_out_valid (io_uart_out_valid),
        .io_uart_out_ch    (io_uart_out_ch),
        .line_if           (lif),
        .trap_hit          (trap_hit),
        .trap_code         (trap_code),
        .drop_cnt          (drop_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [8*LB-1:0] obs, input logic [8*LB-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string s, input bit partial);
        exp_t e;
        e.data = '0;
        for (int i = 0; i < s.len(); i++) e.data[8*i +: 8] = s[i];
        e.len     = s.len();
        e.partial = partial;
        sb.push_back(e);
    endtask

    // Character is sampled at the next rising edge; returns 1 time unit after it.
    task automatic put(input logic [7:0] c);
        io_uart_out_ch    = c;
        io_uart_out_valid = 1'b1;
        @(posedge clock);
        #1;
        io_uart_out_valid = 1'b0;
    endtask

    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    // Printer side: compare each accepted line against the scoreboard head.
    always @(negedge clock) begin
        if (!reset && lif.line_valid && lif.line_ready) begin
            checks++;
            assert (sb.size() > 0)
            else begin
                errors++;
                $error("FAIL unexpected_line observed_len=%0d expected=no line", lif.line_len);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("line_data", lif.line_data, e.data);
                check("line_len", lif.line_len, e.len);
                check("line_partial", lif.line_partial, e.partial);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string a64;
        reset             = 1'b1;
        io_uart_out_valid = 1'b0;
        io_uart_out_ch    = 8'h00;
        lif.line_ready    = 1'b0;
        idle(3);
        check("rst_valid", lif.line_valid, 0);
        check("rst_data", lif.line_data, 0);
        check("rst_len", lif.line_len, 0);
        check("rst_partial", lif.line_partial, 0);
        check("rst_trap_hit", trap_hit, 0);
        check("rst_trap_code", trap_code, 0);
        check("rst_drop", drop_cnt, 0);
        reset          = 1'b0;
        lif.line_ready = 1'b1;

        // "hi\n": line visible the cycle after the LF edge
        push_exp("hi\n", 0);
        put(8'h68);
        put(8'h69);
        put(8'h0A);
        check("hi_latency", lif.line_valid, 1);
        wait_empty("hi_done", 10);

        // 65 'A': full line of 64, then the lone 65th char idle-flushes
        a64 = "";
        for (int i = 0; i < 64; i++) a64 = {a64, "A"};
        push_exp(a64, 1);
        push_exp("A", 1);
        put_str(a64);
        put(8'h41);
        wait_empty("full_line_done", 30);

        // Backpressure: 4 lines queue, 5th held pending, 3 chars dropped
        lif.line_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            string s;
            s = "a\n";
            s[0] = 8'h61 + 8'(i);
            push_exp(s, 0);
            put_str(s);
        end
        check("bp_valid", lif.line_valid, 1);
        check("bp_head_len", lif.line_len, 2);
        put_str("xyz");
        check("bp_drop", drop_cnt, 3);
        lif.line_ready = 1'b1;
        wait_empty("bp_drain", 20);
        check("bp_drop_after", drop_cnt, 3);

        // Idle flush: line appears in the 9th idle cycle
        push_exp("$ ", 1);
        put_str("$ ");
        idle(7);
        check("idle_cycle8", lif.line_valid, 0);
        idle(1);
        check("idle_cycle9", lif.line_valid, 1);
        wait_empty("idle_done", 5);

        // Reset with two queued lines and a 5-char partial buffer
        lif.line_ready = 1'b0;
        put_str("x\ny\nhello");
        check("pre_rst_valid", lif.line_valid, 1);
        reset = 1'b1;
        idle(1);
        check("mid_rst_valid", lif.line_valid, 0);
        check("mid_rst_data", lif.line_data, 0);
        check("mid_rst_len", lif.line_len, 0);
        check("mid_rst_partial", lif.line_partial, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_trap", trap_hit, 0);
        reset          = 1'b0;
        lif.line_ready = 1'b1;
        idle(12);
        check("post_rst_idle", lif.line_valid, 0);
        push_exp("q\n", 0);
        put_str("q\n");
        wait_empty("post_rst_line", 5);

        // Trap after "ok": partial line flushed, trap_hit once the FIFO empties
        lif.line_ready = 1'b0;
        push_exp("ok", 1);
        put_str("ok");
        put(8'h80);
        idle(3);
        check("trap_line_valid", lif.line_valid, 1);
        check("trap_wait_hit", trap_hit, 0);
        lif.line_ready = 1'b1;
        idle(1);
        check("trap_fifo_empty", lif.line_valid, 0);
        check("trap_not_yet", trap_hit, 0);
        idle(1);
        check("trap_hit", trap_hit, 1);
        check("trap_code0", trap_code, 0);
        put_str("z\n");
        idle(3);
        check("trapped_ignore", lif.line_valid, 0);
        check("trapped_nodrop", drop_cnt, 0);
        check("trapped_sticky", trap_hit, 1);
        check("trap_sb_empty", sb.size(), 0);

        // Trap with empty buffer and FIFO: hit two cycles after the trap edge
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rst_clears_trap", trap_hit, 0);
        put(8'hAA);
        check("fast_trap_n1", trap_hit, 0);
        idle(1);
        check("fast_trap_n2", trap_hit, 1);
        check("fast_trap_code", trap_code, 7'h2A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
